pipeline_skid_register: RTL and testbench
=========================================

# pipeline_skid_register

Generic, parametrised inter-stage pipeline register with ready/valid flow control, a two-entry skid buffer, synchronous flush and a stall counter. It replaces fixed per-stage registers such as ID/EX with one block that carries an arbitrary data payload plus an arbitrary control bundle. It sits between any two pipeline stages. Per-stage hold, bubble insertion and back-pressure are handled here rather than through ad hoc clock-phase tricks.

## Interface
- NBits, 32: data payload width (PC+4, operands, immediates, instruction, etc. concatenated).
- NCtrl, 16: control bundle width (ALUOp, Ctrl* flags, write register, etc. concatenated).
- CTRL_BUBBLE, {NCtrl{1'b0}}: control value presented whenever the stage holds no valid entry.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- Flush  in  1  synchronous flush; discards all held entries and the current input.
- in_Valid  in  1  upstream entry valid.
- in_Data  in  NBits  upstream payload.
- in_Ctrl  in  NCtrl  upstream control bundle.
- out_Ready  out  1  upstream may transfer this cycle; registered.
- out_Valid  out  1  entry presented downstream.
- out_Data  out  NBits  payload of head entry.
- out_Ctrl  out  NCtrl  control of head entry.
- in_Ready  in  1  downstream accepts head entry this cycle.
- out_Occupancy  out  2  number of held entries, 0..2.
- out_StallCount  out  CNT_W  cycles with out_Valid=1 and in_Ready=0; saturating.

## Operation
- Push: `in_Valid & out_Ready`. Pop: `out_Valid & in_Ready`.
- Storage: a head register drives `out_*`; a skid register holds the second entry.
- States, encoded as occupancy:
  - EMPTY (0)
  - ONE (1): head valid.
  - FULL (2): head and skid valid.
- Transitions:
  - EMPTY: push → ONE, head <= in.
  - ONE: push & !pop → FULL, skid <= in.
  - ONE: pop & !push → EMPTY.
  - ONE: push & pop → ONE, head <= in.
  - ONE: neither → hold.
  - FULL: pop → ONE, head <= skid.
  - FULL: no pop → hold. Push is impossible because out_Ready=0.
- out_Ready = (state != FULL). It is a registered value, derived from next-state.
- Bubble semantics: whenever out_Valid=0, out_Data=0 and out_Ctrl=CTRL_BUBBLE. The head register is cleared on every entry to EMPTY.
- Flush:
  - Priority is below reset and above push/pop.
  - Next state is EMPTY; the head is cleared to bubble and the skid is discarded.
  - An input offered in the same cycle is dropped. out_Ready still reads its pre-flush value that cycle, so upstream must treat the beat as consumed.
  - A pop in the flush cycle still completes from the downstream view.
- Reset:
  - State EMPTY, head = bubble, skid = 0, out_StallCount = 0.
  - out_Ready = 1 from the first edge with reset high.
  - Reset mid-transfer discards everything.
- Stall counter:
  - Increments by 1 in each cycle where out_Valid & !in_Ready, evaluated before the edge.
  - Holds at {CNT_W{1'b1}}.
  - Cleared only by reset; Flush does not clear it.
- Widths: out_Occupancy is zero-extended state. No arithmetic is performed on payload or control.

## Timing
- Latency: 1 cycle. A push in cycle N from EMPTY makes out_Valid=1 in N+1.
- Throughput: 1 entry/cycle sustained while in_Ready=1.
- Back-pressure: when in_Ready drops, at most one further beat is absorbed (into skid). out_Ready falls in the cycle after entering FULL.
- Recovery: FULL → ONE on the first pop. out_Ready returns high the next cycle.
- Combinational paths: none from in_Ready or in_Valid to out_Ready. All outputs are registered.

## Structure
- Shared package `pipeline_pkg`: occupancy/state constants (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2) and the default CTRL_BUBBLE.
- One sub-module: `sat_counter` (parameter W; ports clk, reset, inc, count), used for out_StallCount and reusable by other stages' performance counters.
- Per-stage wrappers (ID/EX, EX/MEM) only pack and unpack fields into in_Data/in_Ctrl.

## Test plan
- Reset → out_Valid=0, out_Data=0, out_Ctrl=CTRL_BUBBLE, out_Ready=1, out_Occupancy=0, out_StallCount=0.
- Streaming with in_Ready=1 and data 0x10..0x17 on consecutive cycles → identical sequence on out_Data, one cycle later, no gaps; out_Ready stays 1.
- Push 0xA1, 0xA2, 0xA3 with in_Ready=0 → accepts 0xA1 and 0xA2; out_Ready=0 and occupancy=2. Then in_Ready=1 → outputs 0xA1, then 0xA2, then 0xA3 (accepted after out_Ready returns); none lost.
- FULL state, then Flush=1 with in_Valid=1 and data 0xFF → next cycle out_Valid=0, out_Ctrl=CTRL_BUBBLE, occupancy=0, and 0xFF never appears at the output.
- Hold out_Valid=1 with in_Ready=0 for 5 cycles → out_StallCount=5. With CNT_W=4, 20 stall cycles → count=15, then holds. Flush leaves the count unchanged.
- Reset asserted while FULL with a push pending → next cycle EMPTY with bubble outputs; the first post-reset push appears after 1 cycle.

Source files
------------

// File: rtl/pipeline_skid_register_pkg.sv
// Shared definitions for the pipeline skid register: occupancy-encoded
// state values and the default control bubble.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

  // Default control value driven while no entry is held; replicated to NCtrl.
  localparam logic CTRL_BUBBLE_BIT = 1'b0;

endpackage

// File: rtl/pipeline_skid_register_sat_counter.sv
// Saturating up-counter: counts cycles where inc is high, sticks at all-ones,
// cleared only by reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_skid_register.sv
// Inter-stage pipeline register with a two-entry skid buffer, synchronous
// flush and a saturating downstream stall counter. All outputs are registered.
module pipeline_skid_register
  import pipeline_pkg::*;
#(
  parameter int                NBits       = 32,
  parameter int                NCtrl       = 16,
  parameter logic [NCtrl-1:0]  CTRL_BUBBLE = {NCtrl{CTRL_BUBBLE_BIT}},
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Flush,
  input  logic              in_Valid,
  input  logic [NBits-1:0]  in_Data,
  input  logic [NCtrl-1:0]  in_Ctrl,
  output logic              out_Ready,
  output logic              out_Valid,
  output logic [NBits-1:0]  out_Data,
  output logic [NCtrl-1:0]  out_Ctrl,
  input  logic              in_Ready,
  output logic [1:0]        out_Occupancy,
  output logic [CNT_W-1:0]  out_StallCount
);

  // Handshake: a beat moves on a side only when its valid and ready are both
  // high at the rising edge; valid/data never depend on the same-cycle ready.
  occ_state_e       state_q, state_d;
  logic             ready_q, ready_d;
  logic [NBits-1:0] head_data_q, head_data_d;
  logic [NCtrl-1:0] head_ctrl_q, head_ctrl_d;
  logic [NBits-1:0] skid_data_q, skid_data_d;
  logic [NCtrl-1:0] skid_ctrl_q, skid_ctrl_d;
  logic             push;
  logic             pop;
  logic             stall;

  assign push  = in_Valid & ready_q;
  assign pop   = out_Valid & in_Ready;
  assign stall = out_Valid & ~in_Ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      ready_q     <= 1'b1;
      head_data_q <= '0;
      head_ctrl_q <= CTRL_BUBBLE;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      head_data_q <= head_data_d;
      head_ctrl_q <= head_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  // Next-state and storage update
  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_ctrl_d = head_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    if (Flush) begin
      // Any offered input is dropped; upstream already saw ready and moves on.
      state_d     = ST_EMPTY;
      head_data_d = '0;
      head_ctrl_d = CTRL_BUBBLE;
      skid_data_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d     = ST_ONE;
            head_data_d = in_Data;
            head_ctrl_d = in_Ctrl;
          end
        end
        ST_ONE: begin
          if (push && !pop) begin
            state_d     = ST_FULL;
            skid_data_d = in_Data;
            skid_ctrl_d = in_Ctrl;
          end else if (push && pop) begin
            head_data_d = in_Data;
            head_ctrl_d = in_Ctrl;
          end else if (pop) begin
            // Head is cleared on entry to EMPTY so out_* shows the bubble.
            state_d     = ST_EMPTY;
            head_data_d = '0;
            head_ctrl_d = CTRL_BUBBLE;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d     = ST_ONE;
            head_data_d = skid_data_q;
            head_ctrl_d = skid_ctrl_q;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          head_data_d = '0;
          head_ctrl_d = CTRL_BUBBLE;
        end
      endcase
    end

    ready_d = (state_d != ST_FULL);
  end

  // Outputs come straight from registers; head already holds the bubble when empty.
  always_comb begin
    out_Valid     = (state_q != ST_EMPTY);
    out_Data      = head_data_q;
    out_Ctrl      = head_ctrl_q;
    out_Ready     = ready_q;
    out_Occupancy = state_q;
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall),
    .count (out_StallCount)
  );

endmodule

// File: tb/tb_pipeline_skid_register.sv
// Self-checking bench for pipeline_skid_register against a queue-based model
// of a two-deep FIFO with registered ready and a saturating stall count.
module tb_pipeline_skid_register;

  localparam int              NB   = 32;
  localparam int              NC   = 16;
  localparam int              CW   = 4;
  localparam logic [NC-1:0]   BUB  = 16'h00C3;
  localparam int              CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready = 1'b0;
  logic [NB-1:0] in_data = '0;
  logic [NC-1:0] in_ctrl = '0;
  logic          out_ready;
  logic          out_valid;
  logic [NB-1:0] out_data;
  logic [NC-1:0] out_ctrl;
  logic [1:0]    occ;
  logic [CW-1:0] cnt;

  pipeline_skid_register #(
    .NBits(NB), .NCtrl(NC), .CTRL_BUBBLE(BUB), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .Flush(flush),
    .in_Valid(in_valid), .in_Data(in_data), .in_Ctrl(in_ctrl),
    .out_Ready(out_ready), .out_Valid(out_valid), .out_Data(out_data),
    .out_Ctrl(out_ctrl), .in_Ready(in_ready),
    .out_Occupancy(occ), .out_StallCount(cnt)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO of {ctrl,data}, registered ready, stall count.
  logic [NB+NC-1:0] exp_q[$];
  logic [NB-1:0]    got_q[$];
  int               m_cnt = 0;
  bit               m_ready = 1'b1;
  int               vectors = 0;
  int               miscompares = 0;

  function automatic logic exp_valid();
    return exp_q.size() != 0;
  endfunction

  function automatic logic [NB-1:0] exp_data();
    logic [NB+NC-1:0] e;
    if (exp_q.size() == 0) return '0;
    e = exp_q[0];
    return e[NB-1:0];
  endfunction

  function automatic logic [NC-1:0] exp_ctrl();
    logic [NB+NC-1:0] e;
    if (exp_q.size() == 0) return BUB;
    e = exp_q[0];
    return e[NB+NC-1:NB];
  endfunction

  function automatic logic [1:0] exp_occ();
    return 2'(exp_q.size());
  endfunction

  // One clock: model follows the edge, outputs are sampled 1ns after it.
  task automatic step();
    bit push, pop, stall;
    push  = in_valid && m_ready;
    pop   = exp_valid() && in_ready;
    stall = exp_valid() && !in_ready;
    if (out_valid && in_ready) got_q.push_back(out_data);
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      m_cnt   = 0;
      m_ready = 1'b1;
    end else begin
      if (stall && m_cnt < CMAX) m_cnt++;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (pop) void'(exp_q.pop_front());
        if (push) exp_q.push_back({in_ctrl, in_data});
      end
      m_ready = exp_q.size() < 2;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD; in_ready = 1'b0;
    step(); step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL reset_data: got %0h want 0", out_data); end
    vectors++; if (out_ctrl !== BUB) begin miscompares++; $display("FAIL reset_ctrl: got %0h want %0h", out_ctrl, BUB); end
    vectors++; if (out_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %0b want 1", out_ready); end
    vectors++; if (occ !== 2'd0) begin miscompares++; $display("FAIL reset_occ: got %0d want 0", occ); end
    vectors++; if (cnt !== '0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
    reset = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_stream();
    in_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 32'h10 + i; in_ctrl = 16'($urandom);
      step();
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d]: got %0b want 1", i, out_valid); end
      vectors++; if (out_data !== 32'h10 + i) begin miscompares++; $display("FAIL stream_data[%0d]: got %0h want %0h", i, out_data, 32'h10 + i); end
      vectors++; if (out_ctrl !== exp_ctrl()) begin miscompares++; $display("FAIL stream_ctrl[%0d]: got %0h want %0h", i, out_ctrl, exp_ctrl()); end
      vectors++; if (out_ready !== 1'b1) begin miscompares++; $display("FAIL stream_ready[%0d]: got %0b want 1", i, out_ready); end
    end
    in_valid = 1'b0;
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_drain_valid: got %0b want 0", out_valid); end
    vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL stream_drain_data: got %0h want 0", out_data); end
  endtask

  task automatic test_backpressure();
    got_q.delete();
    in_ready = 1'b0; in_ctrl = 16'h0A0A;
    in_valid = 1'b1; in_data = 32'hA1; step();
    in_data = 32'hA2; step();
    in_data = 32'hA3; step();
    vectors++; if (out_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready_low: got %0b want 0", out_ready); end
    vectors++; if (occ !== 2'd2) begin miscompares++; $display("FAIL bp_occ_full: got %0d want 2", occ); end
    vectors++; if (out_data !== 32'hA1) begin miscompares++; $display("FAIL bp_head: got %0h want a1", out_data); end
    in_ready = 1'b1; step();
    vectors++; if (occ !== 2'd1) begin miscompares++; $display("FAIL bp_occ_one: got %0d want 1", occ); end
    vectors++; if (out_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_back: got %0b want 1", out_ready); end
    vectors++; if (out_data !== 32'hA2) begin miscompares++; $display("FAIL bp_second: got %0h want a2", out_data); end
    step();
    in_valid = 1'b0;
    vectors++; if (out_data !== 32'hA3) begin miscompares++; $display("FAIL bp_third: got %0h want a3", out_data); end
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drained: got %0b want 0", out_valid); end
    vectors++; if (got_q.size() != 3) begin miscompares++; $display("FAIL bp_count: got %0d want 3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      vectors++;
      if (got_q[i] !== 32'hA1 + i) begin miscompares++; $display("FAIL bp_order[%0d]: got %0h want %0h", i, got_q[i], 32'hA1 + i); end
    end
  endtask

  task automatic test_flush();
    in_ready = 1'b0; in_ctrl = 16'h5555;
    in_valid = 1'b1; in_data = 32'hB1; step();
    in_data = 32'hB2; step();
    vectors++; if (occ !== 2'd2) begin miscompares++; $display("FAIL flush_pre_occ: got %0d want 2", occ); end
    flush = 1'b1; in_data = 32'hFF; step();
    flush = 1'b0; in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %0b want 0", out_valid); end
    vectors++; if (out_ctrl !== BUB) begin miscompares++; $display("FAIL flush_ctrl: got %0h want %0h", out_ctrl, BUB); end
    vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL flush_data: got %0h want 0", out_data); end
    vectors++; if (occ !== 2'd0) begin miscompares++; $display("FAIL flush_occ: got %0d want 0", occ); end
    vectors++; if (out_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready: got %0b want 1", out_ready); end
    vectors++; if (cnt !== CW'(m_cnt)) begin miscompares++; $display("FAIL flush_cnt: got %0d want %0d", cnt, m_cnt); end
    in_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_ghost[%0d]: got %0b want 0", i, out_valid); end
    end
  endtask

  task automatic test_stall_count();
    reset = 1'b1; step(); reset = 1'b0;
    in_ready = 1'b0; in_valid = 1'b1; in_data = 32'hD1; step();
    in_valid = 1'b0;
    repeat (5) step();
    vectors++; if (cnt !== CW'(5)) begin miscompares++; $display("FAIL stall_5: got %0d want 5", cnt); end
    repeat (15) step();
    vectors++; if (cnt !== CW'(15)) begin miscompares++; $display("FAIL stall_sat: got %0d want 15", cnt); end
    repeat (3) step();
    vectors++; if (cnt !== CW'(15)) begin miscompares++; $display("FAIL stall_hold: got %0d want 15", cnt); end
    flush = 1'b1; step(); flush = 1'b0;
    vectors++; if (cnt !== CW'(15)) begin miscompares++; $display("FAIL stall_flush_sat: got %0d want 15", cnt); end
    reset = 1'b1; step(); reset = 1'b0;
    in_valid = 1'b1; in_data = 32'hD2; step();
    in_valid = 1'b0;
    repeat (3) step();
    flush = 1'b1; step(); flush = 1'b0;
    vectors++; if (cnt !== CW'(4)) begin miscompares++; $display("FAIL stall_flush_keep: got %0d want 4", cnt); end
    repeat (2) step();
    vectors++; if (cnt !== CW'(4)) begin miscompares++; $display("FAIL stall_idle_keep: got %0d want 4", cnt); end
  endtask

  task automatic test_reset_full();
    in_ready = 1'b0; in_ctrl = 16'h7777;
    in_valid = 1'b1; in_data = 32'hE1; step();
    in_data = 32'hE2; step();
    in_data = 32'hE3; reset = 1'b1; step();
    reset = 1'b0; in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstfull_valid: got %0b want 0", out_valid); end
    vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL rstfull_data: got %0h want 0", out_data); end
    vectors++; if (out_ctrl !== BUB) begin miscompares++; $display("FAIL rstfull_ctrl: got %0h want %0h", out_ctrl, BUB); end
    vectors++; if (occ !== 2'd0) begin miscompares++; $display("FAIL rstfull_occ: got %0d want 0", occ); end
    vectors++; if (out_ready !== 1'b1) begin miscompares++; $display("FAIL rstfull_ready: got %0b want 1", out_ready); end
    vectors++; if (cnt !== '0) begin miscompares++; $display("FAIL rstfull_cnt: got %0d want 0", cnt); end
    in_valid = 1'b1; in_data = 32'hC1; step();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rstfull_push_valid: got %0b want 1", out_valid); end
    vectors++; if (out_data !== 32'hC1) begin miscompares++; $display("FAIL rstfull_push_data: got %0h want c1", out_data); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 19) == 0);
      reset    = ($urandom_range(0, 99) == 0);
      in_data  = $urandom;
      in_ctrl  = 16'($urandom);
      step();
      vectors++; if (out_valid !== exp_valid()) begin miscompares++; $display("FAIL rnd_valid[%0d]: got %0b want %0b", i, out_valid, exp_valid()); end
      vectors++; if (out_data !== exp_data()) begin miscompares++; $display("FAIL rnd_data[%0d]: got %0h want %0h", i, out_data, exp_data()); end
      vectors++; if (out_ctrl !== exp_ctrl()) begin miscompares++; $display("FAIL rnd_ctrl[%0d]: got %0h want %0h", i, out_ctrl, exp_ctrl()); end
      vectors++; if (out_ready !== m_ready) begin miscompares++; $display("FAIL rnd_ready[%0d]: got %0b want %0b", i, out_ready, m_ready); end
      vectors++; if (occ !== exp_occ()) begin miscompares++; $display("FAIL rnd_occ[%0d]: got %0d want %0d", i, occ, exp_occ()); end
      vectors++; if (cnt !== CW'(m_cnt)) begin miscompares++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, cnt, m_cnt); end
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_stall_count();
    test_reset_full();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
